// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the pipelined N:1 word multiplexer tree.
package mux_pipe_pkg;

   localparam int RADIX = 4;

   typedef logic [1:0] sel_slice_t;

   // Number of radix-4 tree levels needed to cover n channels (at least one).
   function automatic int mux_levels(input int n);
      int lv;
      int span;
      lv   = 1;
      span = RADIX;
      while (span < n) begin
         span = span * RADIX;
         lv   = lv + 1;
      end
      return lv;
   endfunction

endpackage

// File: rtl/mux_pipe_n_mux4_stage.sv
// One tree level: GROUPS parallel 4:1 word muxes with registered outputs,
// per-beat valid/select/err carried alongside, and its own load enable.
module mux4_stage
   import mux_pipe_pkg::*;
#(
   parameter int GROUPS   = 1,
   parameter int WIDTH    = 8,
   parameter int SEL_BITS = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_valid,
   input  logic [GROUPS*RADIX*WIDTH-1:0] i_data,
   input  logic [SEL_BITS-1:0]           i_sel,
   input  logic                          i_err,
   input  logic                          i_en_dn,
   output logic                          o_en,
   output logic                          o_valid,
   output logic [GROUPS*WIDTH-1:0]       o_data,
   output logic [SEL_BITS-1:0]           o_sel,
   output logic                          o_err
);

   sel_slice_t                w_slice;
   logic                      w_en;
   logic [GROUPS*WIDTH-1:0]   w_mux;

   logic                      r_valid;
   logic                      r_err;
   logic [GROUPS*WIDTH-1:0]   r_data;
   logic [SEL_BITS-1:0]       r_sel;

   assign w_slice = i_sel[1:0];
   // An empty stage always loads, so bubbles collapse toward the output.
   assign w_en    = ~r_valid | i_en_dn;

   genvar gi;
   generate
      for (gi = 0; gi < GROUPS; gi++) begin : g_grp
         assign w_mux[gi*WIDTH +: WIDTH] =
            i_data[(gi*RADIX + int'(w_slice))*WIDTH +: WIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
      end else if (w_en) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= w_mux;
            r_sel  <= i_sel >> 2;
            r_err  <= i_err;
         end
      end
   end

   assign o_en    = w_en;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_sel   = r_sel;
   assign o_err   = r_err;

endmodule

// File: rtl/mux_pipe_n.sv
// Pipelined N:1 word mux built from radix-4 registered stages with valid/ready.
// Define MUX_SEL_CHECK_EN to flag out-of-range selects on sel_err (data forced to 0).
module mux_pipe_n
   import mux_pipe_pkg::*;
#(
   parameter int N_IN  = 16,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sel_err
);

   localparam int L   = mux_levels(N_IN);
   localparam int SB  = 2 * L;
   localparam int PAD = RADIX ** L;

   logic [PAD*WIDTH-1:0] w_pad;
   logic [SB-1:0]        w_sel0;
   logic                 w_err0;

   logic [SB-1:0]        w_sel   [0:L];
   logic                 w_valid [0:L];
   logic                 w_err   [0:L];
   logic [SB-1:0]        w_sel_unused;

   always_comb begin
      w_pad                    = '0;
      w_pad[N_IN*WIDTH-1:0]    = in_data;
      w_sel0                   = '0;
      w_sel0[SEL_W-1:0]        = in_sel;
`ifdef MUX_SEL_CHECK_EN
      w_err0 = ({1'b0, in_sel} >= (SEL_W+1)'(N_IN));
      if (w_err0) begin
         w_pad = '0;
      end
`else
      w_err0 = 1'b0;
`endif
   end

   assign w_valid[0] = in_valid;
   assign w_sel[0]   = w_sel0;
   assign w_err[0]   = w_err0;

   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_stage
         localparam int GROUPS = RADIX ** (L - gi - 1);
         logic [GROUPS*RADIX*WIDTH-1:0] w_din;
         logic [GROUPS*WIDTH-1:0]       w_q;
         logic                          w_en_up;
         logic                          w_en_dn;

         if (gi == 0) begin : g_head
            assign w_din = w_pad;
         end else begin : g_body
            assign w_din = g_stage[gi-1].w_q;
         end

         // The ready chain runs backward from out_ready through each stage.
         if (gi == L - 1) begin : g_tail
            assign w_en_dn = out_ready;
         end else begin : g_mid
            assign w_en_dn = g_stage[gi+1].w_en_up;
         end

         mux4_stage #(
            .GROUPS   (GROUPS),
            .WIDTH    (WIDTH),
            .SEL_BITS (SB)
         ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[gi]),
            .i_data  (w_din),
            .i_sel   (w_sel[gi]),
            .i_err   (w_err[gi]),
            .i_en_dn (w_en_dn),
            .o_en    (w_en_up),
            .o_valid (w_valid[gi+1]),
            .o_data  (w_q),
            .o_sel   (w_sel[gi+1]),
            .o_err   (w_err[gi+1])
         );
      end
   endgenerate

   assign w_sel_unused = w_sel[L];
   assign in_ready     = g_stage[0].w_en_up;
   assign out_data     = g_stage[L-1].w_q;
   assign out_valid    = w_valid[L];
   assign sel_err      = w_err[L];

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: three instances (N_IN 16, 6, 64) driven one at a time
// against a queue-based scoreboard and a behavioural select model.
module tb_mux_pipe_n;

`ifdef MUX_SEL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam int NSZ    [3] = '{16, 6, 64};
   localparam int LV     [3] = '{2, 2, 3};
   localparam int SELMAX [3] = '{15, 7, 63};

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         cyc;
   } sb_t;

   logic         clk;
   logic         rst;
   logic [511:0] bus;
   logic [23:0]  tsel;
   logic [2:0]   tvalid;
   logic [2:0]   tordy;
   logic [2:0]   ir;
   logic [2:0]   ov;
   logic [2:0]   se;
   logic [23:0]  od;

   sb_t        q[$];
   int         checks;
   int         errors;
   int         cyc;
   int         n_acc;
   bit         fixed_bus;
   bit         stall_prev;
   logic [7:0] prev_data;
   logic       prev_err;
   logic [7:0] last_data;
   logic       last_err;
   int         last_lat;

   mux_pipe_n #(.N_IN(16), .WIDTH(8)) u_dut16 (
      .clk(clk), .rst(rst), .in_data(bus[127:0]), .in_sel(tsel[3:0]),
      .in_valid(tvalid[0]), .in_ready(ir[0]), .out_data(od[7:0]),
      .out_valid(ov[0]), .out_ready(tordy[0]), .sel_err(se[0]));

   mux_pipe_n #(.N_IN(6), .WIDTH(8)) u_dut6 (
      .clk(clk), .rst(rst), .in_data(bus[47:0]), .in_sel(tsel[10:8]),
      .in_valid(tvalid[1]), .in_ready(ir[1]), .out_data(od[15:8]),
      .out_valid(ov[1]), .out_ready(tordy[1]), .sel_err(se[1]));

   mux_pipe_n #(.N_IN(64), .WIDTH(8)) u_dut64 (
      .clk(clk), .rst(rst), .in_data(bus), .in_sel(tsel[21:16]),
      .in_valid(tvalid[2]), .in_ready(ir[2]), .out_data(od[23:16]),
      .out_valid(ov[2]), .out_ready(tordy[2]), .sel_err(se[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_bus();
      for (int i = 0; i < 64; i++) begin
         if (fixed_bus) bus[i*8 +: 8] = 8'(8'h10 + i);
         else           bus[i*8 +: 8] = 8'($urandom);
      end
   endtask

   // Reference: in-range selects pick their channel, anything else reads zero.
   function automatic sb_t model(input int d, input int s);
      sb_t r;
      r.cyc  = cyc;
      r.data = (s < NSZ[d]) ? bus[s*8 +: 8] : 8'h00;
      r.err  = CHK && (s >= NSZ[d]);
      return r;
   endfunction

   task automatic step(input int d, input bit v, input int s, input bit ordy);
      sb_t e;
      @(negedge clk);
      fill_bus();
      tvalid            = '0;
      tvalid[d]         = v;
      tordy             = '1;
      tordy[d]          = ordy;
      tsel[d*8 +: 8]    = 8'(s);
      #1;
      cyc++;
      if (stall_prev) begin
         check("hold_valid", 32'(ov[d]), 32'd1);
         check("hold_data", 32'(od[d*8 +: 8]), 32'(prev_data));
         check("hold_err", 32'(se[d]), 32'(prev_err));
      end
      if (ov[d] && ordy) begin
         if (q.size() == 0) begin
            check("spurious_out", 32'(ov[d]), 32'd0);
         end else begin
            e = q.pop_front();
            last_data = od[d*8 +: 8];
            last_err  = se[d];
            last_lat  = cyc - e.cyc;
            check("out_data", 32'(last_data), 32'(e.data));
            check("out_err", 32'(last_err), 32'(e.err));
            check("lat_min", 32'(last_lat >= LV[d]), 32'd1);
         end
      end
      if (v && ir[d]) begin
         q.push_back(model(d, s));
         n_acc++;
      end
      stall_prev = ov[d] && !ordy;
      prev_data  = od[d*8 +: 8];
      prev_err   = se[d];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst    = 1'b1;
      tvalid = '0;
      tordy  = '1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      stall_prev = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; n_acc = 0;
      fixed_bus = 1'b1; stall_prev = 1'b0;
      last_data = 'x; last_err = 'x; last_lat = -1;
      prev_data = '0; prev_err = 1'b0;
      rst = 1'b1; tvalid = '0; tordy = '1; tsel = '0; bus = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(ov), 32'd0);
      check("rst_out_data", 32'(od), 32'd0);
      check("rst_sel_err", 32'(se), 32'd0);
      check("rst_in_ready", 32'(ir), 32'h7);

      // Single beat, select 5 on the 16-channel instance.
      step(0, 1'b1, 5, 1'b1);
      step(0, 1'b0, 0, 1'b1);
      check("t1_gap", 32'(ov[0]), 32'd0);
      step(0, 1'b0, 0, 1'b1);
      check("t1_valid", 32'(ov[0]), 32'd1);
      check("t1_data", 32'(last_data), 32'h15);
      check("t1_err", 32'(last_err), 32'd0);
      check("t1_lat", 32'(last_lat), 32'd2);

      // Back-to-back stream of every select.
      for (int i = 0; i < 18; i++) begin
         step(0, i < 16, i, 1'b1);
         if (i >= 2) check("t2_stream_valid", 32'(ov[0]), 32'd1);
      end
      check("t2_drain", 32'(q.size()), 32'd0);

      // Backpressure from an empty pipeline: two beats fit, then in_ready drops.
      step(0, 1'b0, 0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(0, 1'b1, k + 3, 1'b0);
         check("t3_in_ready", 32'(ir[0]), 32'(k < 2));
      end
      for (int k = 0; k < 6; k++) step(0, 1'b1, 10 + k, 1'b1);
      for (int k = 0; k < 4; k++) step(0, 1'b0, 0, 1'b1);
      check("t3_drain", 32'(q.size()), 32'd0);

      // Padding and range check on the 6-channel instance.
      step(1, 1'b1, 7, 1'b1);
      step(1, 1'b0, 0, 1'b1);
      step(1, 1'b0, 0, 1'b1);
      check("t4_oor_data", 32'(last_data), 32'd0);
      check("t4_oor_err", 32'(last_err), 32'(CHK));
      step(1, 1'b1, 5, 1'b1);
      step(1, 1'b0, 0, 1'b1);
      step(1, 1'b0, 0, 1'b1);
      check("t4_in_data", 32'(last_data), 32'h15);
      check("t4_in_err", 32'(last_err), 32'd0);
      fixed_bus = 1'b0;
      for (int k = 0; k < 400; k++)
         step(1, $urandom_range(0, 3) != 0, int'($urandom_range(0, SELMAX[1])),
              $urandom_range(0, 3) != 0);
      for (int k = 0; k < 20 && q.size() != 0; k++) step(1, 1'b0, 0, 1'b1);
      check("t4_drain", 32'(q.size()), 32'd0);

      // Reset with two beats in flight: neither may ever emerge.
      fixed_bus = 1'b1;
      step(0, 1'b1, 3, 1'b0);
      step(0, 1'b1, 9, 1'b0);
      check("t5_fill", 32'(q.size()), 32'd2);
      do_reset();
      #1;
      check("t5_out_valid", 32'(ov[0]), 32'd0);
      check("t5_in_ready", 32'(ir[0]), 32'd1);
      for (int k = 0; k < 4; k++) begin
         step(0, 1'b0, 0, 1'b1);
         check("t5_no_ghost", 32'(ov[0]), 32'd0);
      end

      // Random valid/ready on the 64-channel, three-level instance.
      fixed_bus = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 60000 && n_acc < 10000; c++)
         step(2, $urandom_range(0, 3) != 0, int'($urandom_range(0, SELMAX[2])),
              $urandom_range(0, 3) != 0);
      check("t6_beats", 32'(n_acc), 32'd10000);
      for (int c = 0; c < 200 && q.size() != 0; c++) step(2, 1'b0, 0, 1'b1);
      check("t6_drain", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
